// File: rtl/bus_arbiter_2to1.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter_2to1
//  Description : Shares one slave bus port between two masters. Grants one
//                request per cycle, records the master ID of every accepted
//                read in an ordering FIFO and routes in-order slave read
//                responses back to the issuing master.
//                Optional feature macro: ARB_ROUND_ROBIN_EN
//                  defined   -> round-robin between masters on conflict
//                  undefined -> fixed priority, master 0 always wins
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter_2to1 #(
    parameter int FIFO_AW = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_addr_bi,
    input  logic [3:0]  m0_be_bi,
    input  logic [31:0] m0_wdata_bi,
    output logic        m0_ack_o,
    output logic        m0_resp_o,
    output logic [31:0] m0_rdata_bo,

    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_addr_bi,
    input  logic [3:0]  m1_be_bi,
    input  logic [31:0] m1_wdata_bi,
    output logic        m1_ack_o,
    output logic        m1_resp_o,
    output logic [31:0] m1_rdata_bo,

    output logic        s_req_o,
    output logic        s_we_o,
    output logic [31:0] s_addr_bo,
    output logic [3:0]  s_be_bo,
    output logic [31:0] s_wdata_bo,
    input  logic        s_ack_i,
    input  logic        s_resp_i,
    input  logic [31:0] s_rdata_bi,

    output logic        err_o
);

    localparam int                c_DEPTH      = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]  c_FULL_COUNT = {1'b1, {FIFO_AW{1'b0}}};

    // ------------------------------------------------------------------
    // State: read-ordering FIFO (one ID bit per entry) and sticky error
    // ------------------------------------------------------------------
    logic [c_DEPTH-1:0]  ids_q,    ids_d;
    logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]    count_q,  count_d;
    logic                err_q,    err_d;

    // ------------------------------------------------------------------
    // Combinational wires
    // ------------------------------------------------------------------
    logic w_fifo_full;
    logic w_fifo_empty;
    logic w_m0_elig;
    logic w_m1_elig;
    logic w_grant_id;
    logic w_s_req;
    logic w_accept;
    logic w_push;
    logic w_pop;
    logic w_head_id;
    logic w_resp_orphan;

    assign w_fifo_full  = (count_q == c_FULL_COUNT);
    assign w_fifo_empty = (count_q == '0);

    // Reads are held off while the FIFO is full; writes never need a slot.
    // A pop in the same cycle does not free a slot for eligibility.
    assign w_m0_elig = m0_req_i & (m0_we_i | ~w_fifo_full);
    assign w_m1_elig = m1_req_i & (m1_we_i | ~w_fifo_full);

`ifdef ARB_ROUND_ROBIN_EN
    // ID of the master granted at the most recent accepted transfer.
    // Resets to 1 so that master 0 wins the first conflict.
    logic last_grant_q, last_grant_d;

    // Next last-grant: follow every accepted transfer.
    always_comb begin
        last_grant_d = last_grant_q;
        if (w_accept) begin
            last_grant_d = w_grant_id;
        end
    end

    // Last-grant register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    // Grant selection: single eligible master wins; conflicts resolved
    // by fixed priority or by round-robin depending on the build.
    always_comb begin
        w_grant_id = 1'b0;
        if (w_m0_elig && w_m1_elig) begin
`ifdef ARB_ROUND_ROBIN_EN
            w_grant_id = ~last_grant_q;
`else
            w_grant_id = 1'b0;
`endif
        end else if (w_m1_elig) begin
            w_grant_id = 1'b1;
        end
    end

    // Slave request is suppressed during reset so nothing is issued.
    assign w_s_req  = (w_m0_elig | w_m1_elig) & ~rst_i;
    assign w_accept = w_s_req & s_ack_i;
    assign w_push   = w_accept & ~s_we_o;

    // Response routing: head of the ordering FIFO names the owner.
    assign w_head_id     = ids_q[rd_ptr_q];
    assign w_pop         = s_resp_i & ~w_fifo_empty & ~rst_i;
    assign w_resp_orphan = s_resp_i &  w_fifo_empty & ~rst_i;

    // Request-path mux: forward the granted master's fields to the slave.
    always_comb begin
        s_req_o    = w_s_req;
        s_we_o     = m0_we_i;
        s_addr_bo  = m0_addr_bi;
        s_be_bo    = m0_be_bi;
        s_wdata_bo = m0_wdata_bi;
        if (w_grant_id) begin
            s_we_o     = m1_we_i;
            s_addr_bo  = m1_addr_bi;
            s_be_bo    = m1_be_bi;
            s_wdata_bo = m1_wdata_bi;
        end
    end

    // Acknowledge only the granted master, in the cycle the slave accepts.
    always_comb begin
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        if (w_accept) begin
            m0_ack_o = ~w_grant_id;
            m1_ack_o =  w_grant_id;
        end
    end

    // Response-path demux: data goes only to the owner, zero elsewhere.
    always_comb begin
        m0_resp_o   = 1'b0;
        m1_resp_o   = 1'b0;
        m0_rdata_bo = '0;
        m1_rdata_bo = '0;
        if (w_pop) begin
            if (w_head_id) begin
                m1_resp_o   = 1'b1;
                m1_rdata_bo = s_rdata_bi;
            end else begin
                m0_resp_o   = 1'b1;
                m0_rdata_bo = s_rdata_bi;
            end
        end
    end

    // FIFO and error next-state: push writes behind the head, pop
    // advances the head, simultaneous push/pop leaves count unchanged.
    always_comb begin
        ids_d    = ids_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        err_d    = err_q | w_resp_orphan;
        if (w_push) begin
            ids_d[wr_ptr_q] = w_grant_id;
            wr_ptr_d        = wr_ptr_q + FIFO_AW'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + (FIFO_AW + 1)'(1);
            2'b01:   count_d = count_q - (FIFO_AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers with synchronous reset (FIFO flushed, error cleared).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ids_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            ids_q    <= ids_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    assign err_o = err_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter_2to1.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_arbiter_2to1
//  Description : Directed self-checking bench for bus_arbiter_2to1.
//                Expected grant order follows ARB_ROUND_ROBIN_EN if defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter_2to1;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i;
    logic [31:0] m0_addr_bi, m0_wdata_bi, m1_addr_bi, m1_wdata_bi;
    logic [3:0]  m0_be_bi, m1_be_bi;
    logic        m0_ack_o, m0_resp_o, m1_ack_o, m1_resp_o;
    logic [31:0] m0_rdata_bo, m1_rdata_bo;
    logic        s_req_o, s_we_o;
    logic [31:0] s_addr_bo, s_wdata_bo;
    logic [3:0]  s_be_bo;
    logic        s_ack_i, s_resp_i;
    logic [31:0] s_rdata_bi;
    logic        err_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    bus_arbiter_2to1 #(.FIFO_AW(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_bi(m0_addr_bi),
        .m0_be_bi(m0_be_bi), .m0_wdata_bi(m0_wdata_bi), .m0_ack_o(m0_ack_o),
        .m0_resp_o(m0_resp_o), .m0_rdata_bo(m0_rdata_bo),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_bi(m1_addr_bi),
        .m1_be_bi(m1_be_bi), .m1_wdata_bi(m1_wdata_bi), .m1_ack_o(m1_ack_o),
        .m1_resp_o(m1_resp_o), .m1_rdata_bo(m1_rdata_bo),
        .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_bo(s_addr_bo),
        .s_be_bo(s_be_bo), .s_wdata_bo(s_wdata_bo), .s_ack_i(s_ack_i),
        .s_resp_i(s_resp_i), .s_rdata_bi(s_rdata_bi), .err_o(err_o)
    );

    // Drive all inputs to quiet values (reset untouched).
    task automatic idle();
        m0_req_i = 0; m0_we_i = 0; m0_addr_bi = 0; m0_be_bi = 0; m0_wdata_bi = 0;
        m1_req_i = 0; m1_we_i = 0; m1_addr_bi = 0; m1_be_bi = 0; m1_wdata_bi = 0;
        s_ack_i = 0; s_resp_i = 0; s_rdata_bi = 0;
    endtask

    // Advance to the next falling edge; inputs then change mid-cycle.
    task automatic next_cycle();
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        rst_i = 1; idle();
        m0_req_i = 1; s_ack_i = 1; s_resp_i = 1; s_rdata_bi = 32'hFFFF_FFFF;
        #1;
        checks++; if (s_req_o !== 1'b0) begin errors++; $display("FAIL rst_s_req: got %b want 0", s_req_o); end
        checks++; if (m0_ack_o !== 1'b0 || m1_ack_o !== 1'b0) begin errors++; $display("FAIL rst_ack: got %b%b want 00", m0_ack_o, m1_ack_o); end
        checks++; if (m0_resp_o !== 1'b0 || m1_resp_o !== 1'b0) begin errors++; $display("FAIL rst_resp: got %b%b want 00", m0_resp_o, m1_resp_o); end
        checks++; if (m0_rdata_bo !== 32'h0 || m1_rdata_bo !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h %h want 0 0", m0_rdata_bo, m1_rdata_bo); end
        next_cycle();
        rst_i = 0; idle();
        #1;
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err_o); end
        checks++; if (s_req_o !== 1'b0) begin errors++; $display("FAIL rst_idle_s_req: got %b want 0", s_req_o); end
        next_cycle();
    endtask

    task automatic test_single_read();
        idle(); m0_req_i = 1; m0_addr_bi = 32'h10; m0_be_bi = 4'hF; s_ack_i = 1;
        #1;
        checks++; if (s_req_o !== 1'b1 || s_we_o !== 1'b0) begin errors++; $display("FAIL single_s_req_we: got %b%b want 10", s_req_o, s_we_o); end
        checks++; if (s_addr_bo !== 32'h10) begin errors++; $display("FAIL single_s_addr: got %h want 10", s_addr_bo); end
        checks++; if (m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0) begin errors++; $display("FAIL single_ack: got %b%b want 10", m0_ack_o, m1_ack_o); end
        next_cycle();
        idle();
        #1;
        checks++; if (m0_ack_o !== 1'b0) begin errors++; $display("FAIL single_ack_once: got %b want 0", m0_ack_o); end
        next_cycle();
        s_resp_i = 1; s_rdata_bi = 32'h1234;
        #1;
        checks++; if (m0_resp_o !== 1'b1 || m0_rdata_bo !== 32'h1234) begin errors++; $display("FAIL single_m0_resp: got %b %h want 1 1234", m0_resp_o, m0_rdata_bo); end
        checks++; if (m1_resp_o !== 1'b0 || m1_rdata_bo !== 32'h0) begin errors++; $display("FAIL single_m1_resp: got %b %h want 0 0", m1_resp_o, m1_rdata_bo); end
        next_cycle();
        idle();
        #1;
        checks++; if (m0_resp_o !== 1'b0 || err_o !== 1'b0) begin errors++; $display("FAIL single_after: got resp %b err %b want 0 0", m0_resp_o, err_o); end
        next_cycle();
    endtask

    task automatic test_conflict();
        logic first_m0;
`ifdef ARB_ROUND_ROBIN_EN
        first_m0 = 1'b0;   // m0 was granted last, so m1 goes first
`else
        first_m0 = 1'b1;
`endif
        idle();
        m0_req_i = 1; m0_addr_bi = 32'h20; m0_be_bi = 4'hF;
        m1_req_i = 1; m1_we_i = 1; m1_addr_bi = 32'h30; m1_be_bi = 4'h3; m1_wdata_bi = 32'hCAFE;
        s_ack_i = 1;
        #1;
        checks++; if (m0_ack_o !== first_m0 || m1_ack_o !== ~first_m0) begin errors++; $display("FAIL conflict_c1_ack: got %b%b want %b%b", m0_ack_o, m1_ack_o, first_m0, ~first_m0); end
        checks++; if (s_addr_bo !== (first_m0 ? 32'h20 : 32'h30)) begin errors++; $display("FAIL conflict_c1_addr: got %h", s_addr_bo); end
        next_cycle();
        if (first_m0) m0_req_i = 0; else m1_req_i = 0;
        #1;
        checks++; if (m0_ack_o !== ~first_m0 || m1_ack_o !== first_m0) begin errors++; $display("FAIL conflict_c2_ack: got %b%b want %b%b", m0_ack_o, m1_ack_o, ~first_m0, first_m0); end
        checks++; if (s_we_o !== first_m0 || s_addr_bo !== (first_m0 ? 32'h30 : 32'h20)) begin errors++; $display("FAIL conflict_c2_fields: got we %b addr %h", s_we_o, s_addr_bo); end
        if (first_m0) begin
            checks++; if (s_wdata_bo !== 32'hCAFE || s_be_bo !== 4'h3) begin errors++; $display("FAIL conflict_wdata: got %h %h want CAFE 3", s_wdata_bo, s_be_bo); end
        end
        next_cycle();
        idle(); s_resp_i = 1; s_rdata_bi = 32'h55;
        #1;
        checks++; if (m0_resp_o !== 1'b1 || m0_rdata_bo !== 32'h55 || m1_resp_o !== 1'b0) begin errors++; $display("FAIL conflict_resp: got %b %h %b want 1 55 0", m0_resp_o, m0_rdata_bo, m1_resp_o); end
        next_cycle();
        idle();
        next_cycle();
    endtask

    task automatic test_alternate();
        logic exp_g;
        idle();
        m0_req_i = 1; m0_we_i = 1; m0_addr_bi = 32'h50;
        m1_req_i = 1; m1_we_i = 1; m1_addr_bi = 32'h60;
        s_ack_i = 1;
        for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_g = (i % 2 == 0);
`else
            exp_g = 1'b0;
`endif
            #1;
            checks++; if (m0_ack_o !== ~exp_g || m1_ack_o !== exp_g) begin errors++; $display("FAIL alternate_%0d: got %b%b want %b%b", i, m0_ack_o, m1_ack_o, ~exp_g, exp_g); end
            next_cycle();
        end
        idle();
        next_cycle();
    endtask

    task automatic test_order();
        idle(); m0_req_i = 1; m0_addr_bi = 32'hA0; s_ack_i = 1;
        #1;
        checks++; if (m0_ack_o !== 1'b1) begin errors++; $display("FAIL order_ack_a: got %b want 1", m0_ack_o); end
        next_cycle();
        m0_req_i = 0; m1_req_i = 1; m1_addr_bi = 32'hB0;
        #1;
        checks++; if (m1_ack_o !== 1'b1 || s_addr_bo !== 32'hB0) begin errors++; $display("FAIL order_ack_b: got %b %h want 1 B0", m1_ack_o, s_addr_bo); end
        next_cycle();
        m1_req_i = 0; m0_req_i = 1; m0_addr_bi = 32'hC0;
        #1;
        checks++; if (m0_ack_o !== 1'b1) begin errors++; $display("FAIL order_ack_c: got %b want 1", m0_ack_o); end
        next_cycle();
        idle(); s_resp_i = 1; s_rdata_bi = 32'hA;
        #1;
        checks++; if (m0_resp_o !== 1'b1 || m0_rdata_bo !== 32'hA || m1_resp_o !== 1'b0) begin errors++; $display("FAIL order_resp_a: got %b %h %b want 1 A 0", m0_resp_o, m0_rdata_bo, m1_resp_o); end
        next_cycle();
        s_rdata_bi = 32'hB;
        #1;
        checks++; if (m1_resp_o !== 1'b1 || m1_rdata_bo !== 32'hB || m0_resp_o !== 1'b0 || m0_rdata_bo !== 32'h0) begin errors++; $display("FAIL order_resp_b: got %b %h %b %h want 1 B 0 0", m1_resp_o, m1_rdata_bo, m0_resp_o, m0_rdata_bo); end
        next_cycle();
        s_rdata_bi = 32'hC;
        #1;
        checks++; if (m0_resp_o !== 1'b1 || m0_rdata_bo !== 32'hC || m1_resp_o !== 1'b0) begin errors++; $display("FAIL order_resp_c: got %b %h %b want 1 C 0", m0_resp_o, m0_rdata_bo, m1_resp_o); end
        next_cycle();
        idle();
        next_cycle();
    endtask

    task automatic test_full();
        idle(); m0_req_i = 1; s_ack_i = 1;
        for (int i = 0; i < 4; i++) begin
            m0_addr_bi = 32'h100 + 32'(i * 4);
            #1;
            checks++; if (m0_ack_o !== 1'b1) begin errors++; $display("FAIL full_fill_%0d: got %b want 1", i, m0_ack_o); end
            next_cycle();
        end
        m0_addr_bi = 32'h200;
        m1_req_i = 1; m1_we_i = 1; m1_addr_bi = 32'h300; m1_wdata_bi = 32'h77;
        #1;
        checks++; if (m0_ack_o !== 1'b0 || m1_ack_o !== 1'b1) begin errors++; $display("FAIL full_ack: got %b%b want 01", m0_ack_o, m1_ack_o); end
        checks++; if (s_req_o !== 1'b1 || s_we_o !== 1'b1 || s_addr_bo !== 32'h300) begin errors++; $display("FAIL full_write_fwd: got %b %b %h want 1 1 300", s_req_o, s_we_o, s_addr_bo); end
        next_cycle();
        m1_req_i = 0; m1_we_i = 0; s_resp_i = 1; s_rdata_bi = 32'h111;
        #1;
        checks++; if (m0_resp_o !== 1'b1 || m0_rdata_bo !== 32'h111) begin errors++; $display("FAIL full_pop_resp: got %b %h want 1 111", m0_resp_o, m0_rdata_bo); end
        checks++; if (m0_ack_o !== 1'b0 || s_req_o !== 1'b0) begin errors++; $display("FAIL full_no_bypass: got ack %b sreq %b want 0 0", m0_ack_o, s_req_o); end
        next_cycle();
        s_resp_i = 0;
        #1;
        checks++; if (m0_ack_o !== 1'b1 || s_req_o !== 1'b1 || s_addr_bo !== 32'h200) begin errors++; $display("FAIL full_fifth_ack: got %b %b %h want 1 1 200", m0_ack_o, s_req_o, s_addr_bo); end
        next_cycle();
        idle(); s_resp_i = 1;
        for (int i = 0; i < 4; i++) begin
            s_rdata_bi = 32'h120 + 32'(i);
            #1;
            checks++; if (m0_resp_o !== 1'b1 || m0_rdata_bo !== 32'h120 + 32'(i)) begin errors++; $display("FAIL full_drain_%0d: got %b %h", i, m0_resp_o, m0_rdata_bo); end
            next_cycle();
        end
        idle();
        next_cycle();
    endtask

    task automatic test_back_to_back();
        idle(); m0_req_i = 1; m0_addr_bi = 32'h40; s_ack_i = 1;
        next_cycle();
        m0_req_i = 0; m1_req_i = 1; m1_addr_bi = 32'h44;
        #1;
        checks++; if (m1_ack_o !== 1'b1) begin errors++; $display("FAIL b2b_m1_ack: got %b want 1", m1_ack_o); end
        next_cycle();
        m1_req_i = 0; m0_req_i = 1; m0_addr_bi = 32'h48; s_resp_i = 1; s_rdata_bi = 32'h1;
        #1;
        checks++; if (m0_ack_o !== 1'b1 || m0_resp_o !== 1'b1 || m0_rdata_bo !== 32'h1 || m1_resp_o !== 1'b0) begin errors++; $display("FAIL b2b_pushpop: got ack %b resp %b %h m1 %b", m0_ack_o, m0_resp_o, m0_rdata_bo, m1_resp_o); end
        next_cycle();
        m0_req_i = 0; s_ack_i = 0; s_rdata_bi = 32'h2;
        #1;
        checks++; if (m1_resp_o !== 1'b1 || m1_rdata_bo !== 32'h2 || m0_resp_o !== 1'b0) begin errors++; $display("FAIL b2b_second: got %b %h %b want 1 2 0", m1_resp_o, m1_rdata_bo, m0_resp_o); end
        next_cycle();
        s_rdata_bi = 32'h3;
        #1;
        checks++; if (m0_resp_o !== 1'b1 || m0_rdata_bo !== 32'h3 || m1_resp_o !== 1'b0) begin errors++; $display("FAIL b2b_third: got %b %h %b want 1 3 0", m0_resp_o, m0_rdata_bo, m1_resp_o); end
        next_cycle();
        idle();
        #1;
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL b2b_err: got %b want 0", err_o); end
        next_cycle();
    endtask

    task automatic test_err();
        idle(); s_resp_i = 1; s_rdata_bi = 32'h99;
        #1;
        checks++; if (m0_resp_o !== 1'b0 || m1_resp_o !== 1'b0) begin errors++; $display("FAIL err_no_resp: got %b%b want 00", m0_resp_o, m1_resp_o); end
        checks++; if (m0_rdata_bo !== 32'h0 || m1_rdata_bo !== 32'h0) begin errors++; $display("FAIL err_rdata: got %h %h want 0 0", m0_rdata_bo, m1_rdata_bo); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL err_same_cycle: got %b want 0", err_o); end
        next_cycle();
        idle();
        #1;
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", err_o); end
        next_cycle();
        #1;
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_held: got %b want 1", err_o); end
        rst_i = 1;
        next_cycle();
        rst_i = 0;
        #1;
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL err_cleared: got %b want 0", err_o); end
        next_cycle();
    endtask

    initial begin
        rst_i = 1;
        idle();
        next_cycle();
        test_reset();
        test_single_read();
        test_conflict();
        test_alternate();
        test_order();
        test_full();
        test_back_to_back();
        test_err();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
